// File: rtl/cpu_isa_pkg.sv
// cpu_isa_pkg: shared ISA constants for the instruction encoder.
//   - opcode constants for the supported instruction classes
//   - ALU function codes used by the encoder
//   - bit positions of the instruction fields
//   - FSM state type of the loader (IDLE / LOAD / FULL)
package cpu_isa_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ORI   = 6'b001101;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b011;

  localparam int unsigned OP_LSB  = 26;
  localparam int unsigned RS_LSB  = 21;
  localparam int unsigned RT_LSB  = 16;
  localparam int unsigned RD_LSB  = 11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    FULL = 2'd2
  } enc_state_t;

endpackage

// File: rtl/instr_encoder_if.sv
// instr_encoder_if: request bundle into the instruction encoder.
//   master modport: request producer (drives in_valid and fields, sees in_ready)
//   slave  modport: encoder side (receives request, drives in_ready)
// Signals: in_valid/in_ready handshake, control intent (jump, ram_load,
// ram_write, imm_enable, alu_func), register fields rs/rt/rd, 26-bit imm.
interface instr_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic        in_jump;
  logic        in_ram_load;
  logic        in_ram_write;
  logic        in_imm_enable;
  logic [2:0]  in_alu_func;
  logic [4:0]  in_rs;
  logic [4:0]  in_rt;
  logic [4:0]  in_rd;
  logic [25:0] in_imm;

  modport master (
    output in_valid, in_jump, in_ram_load, in_ram_write, in_imm_enable,
           in_alu_func, in_rs, in_rt, in_rd, in_imm,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_jump, in_ram_load, in_ram_write, in_imm_enable,
           in_alu_func, in_rs, in_rt, in_rd, in_imm,
    output in_ready
  );
endinterface

// File: rtl/instr_enc_fields.sv
// instr_enc_fields: purely combinational request -> instruction word.
// Ports:
//   jump, ram_load, ram_write, imm_enable, alu_func, rs, rt, rd, imm : request
//   op      : 6-bit opcode chosen by priority jump > lw > sw > ori > R-type
//   func    : 4-bit func field (R-type only, else 0)
//   word    : full 32-bit encoded instruction
//   illegal : request is ambiguous/inconsistent (only with ENC_ILLEGAL_CHECK_EN,
//             otherwise constant 0)
// Config macro: ENC_ILLEGAL_CHECK_EN
module instr_enc_fields
  import cpu_isa_pkg::*;
(
  input  logic        jump,
  input  logic        ram_load,
  input  logic        ram_write,
  input  logic        imm_enable,
  input  logic [2:0]  alu_func,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [25:0] imm,
  output logic [5:0]  op,
  output logic [3:0]  func,
  output logic [31:0] word,
  output logic        illegal
);

  always_comb begin
    op   = OP_RTYPE;
    func = '0;
    word = '0;
    if (jump) begin
      op         = OP_J;
      word[25:0] = imm;
    end else if (ram_load || ram_write || imm_enable) begin
      if (ram_load)       op = OP_LW;
      else if (ram_write) op = OP_SW;
      else                op = OP_ORI;
      word[RS_LSB +: 5] = rs;
      word[RT_LSB +: 5] = rt;
      word[15:0]        = imm[15:0];
    end else begin
      func              = {1'b0, alu_func};
      word[RS_LSB +: 5] = rs;
      word[RT_LSB +: 5] = rt;
      word[RD_LSB +: 5] = rd;
      word[3:0]         = func;
    end
    word[OP_LSB +: 6] = op;
  end

`ifdef ENC_ILLEGAL_CHECK_EN
  logic [2:0] n_ctrl;
  assign n_ctrl  = 3'(jump) + 3'(ram_load) + 3'(ram_write) + 3'(imm_enable);
  assign illegal = (n_ctrl > 3'd1) || (imm_enable && (alu_func != ALU_OR));
`else
  assign illegal = 1'b0;
`endif

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: re-encodes decoded control intent into 32-bit MIPS-style
// words and streams them into instruction memory at incrementing addresses.
// Parameters: AW - imem address width (capacity 2**AW words)
// Ports:
//   clk, rst_n     : clock (rising edge), asynchronous active-low reset
//   start, stop    : pulse to (re)start loading / return to IDLE
//   req            : instr_encoder_if.slave request bundle (valid/ready + fields)
//   imem_we        : one-cycle write strobe per accepted request
//   imem_addr      : write address, imem_wdata : encoded word
//   op_out/func_out: opcode/func of the word on imem_wdata
//   count          : words written since start, full : count == 2**AW
//   err            : sticky illegal-request flag
// Config macro: ENC_ILLEGAL_CHECK_EN (err stays 0 when undefined)
module instr_encoder
  import cpu_isa_pkg::*;
#(
  parameter int unsigned AW = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                stop,
  instr_encoder_if.slave      req,
  output logic                imem_we,
  output logic [AW-1:0]       imem_addr,
  output logic [31:0]         imem_wdata,
  output logic [5:0]          op_out,
  output logic [3:0]          func_out,
  output logic [AW:0]         count,
  output logic                full,
  output logic                err
);

  localparam logic [AW:0] CAPACITY = {1'b1, {AW{1'b0}}};

  enc_state_t  state, state_next;
  logic        ready;
  logic        accept;
  logic [5:0]  enc_op;
  logic [3:0]  enc_func;
  logic [31:0] enc_word;
  logic        enc_illegal;

  instr_enc_fields u_fields (
    .jump       (req.in_jump),
    .ram_load   (req.in_ram_load),
    .ram_write  (req.in_ram_write),
    .imm_enable (req.in_imm_enable),
    .alu_func   (req.in_alu_func),
    .rs         (req.in_rs),
    .rt         (req.in_rt),
    .rd         (req.in_rd),
    .imm        (req.in_imm),
    .op         (enc_op),
    .func       (enc_func),
    .word       (enc_word),
    .illegal    (enc_illegal)
  );

  assign full         = (count == CAPACITY);
  assign req.in_ready = ready;

  // start takes precedence over stop when both pulse together
  always_comb begin
    state_next = state;
    ready      = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = LOAD;
      end
      LOAD: begin
        ready  = !full && !start && !stop;
        accept = ready && req.in_valid;
        if (start)     state_next = LOAD;
        else if (stop) state_next = IDLE;
        else if (full) state_next = FULL;
      end
      FULL: begin
        if (start)     state_next = LOAD;
        else if (stop) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // count advances at accept so a back-to-back request sees the next address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      op_out     <= '0;
      func_out   <= '0;
      count      <= '0;
      err        <= 1'b0;
    end else begin
      imem_we <= accept;
      if (start) begin
        count     <= '0;
        imem_addr <= '0;
        err       <= 1'b0;
      end else if (accept) begin
        imem_addr  <= count[AW-1:0];
        imem_wdata <= enc_word;
        op_out     <= enc_op;
        func_out   <= enc_func;
        count      <= count + 1'b1;
        err        <= err | enc_illegal;
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;
  import cpu_isa_pkg::*;

  localparam int unsigned AW = 2;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          stop;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic [5:0]    op_out;
  logic [3:0]    func_out;
  logic [AW:0]   count;
  logic          full;
  logic          err;

  int unsigned n_total;
  int unsigned n_bad;

  instr_encoder_if bus();

  instr_encoder #(.AW(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stop       (stop),
    .req        (bus.slave),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .op_out     (op_out),
    .func_out   (func_out),
    .count      (count),
    .full       (full),
    .err        (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%08h want=0x%08h", tag, got, exp);
    end
  endtask

  task automatic idle_req();
    bus.in_valid      = 1'b0;
    bus.in_jump       = 1'b0;
    bus.in_ram_load   = 1'b0;
    bus.in_ram_write  = 1'b0;
    bus.in_imm_enable = 1'b0;
    bus.in_alu_func   = '0;
    bus.in_rs         = '0;
    bus.in_rt         = '0;
    bus.in_rd         = '0;
    bus.in_imm        = '0;
  endtask

  task automatic drive(input logic j, input logic lw, input logic sw, input logic ie,
                       input logic [2:0] af, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [25:0] imm);
    bus.in_valid      = 1'b1;
    bus.in_jump       = j;
    bus.in_ram_load   = lw;
    bus.in_ram_write  = sw;
    bus.in_imm_enable = ie;
    bus.in_alu_func   = af;
    bus.in_rs         = rs;
    bus.in_rt         = rt;
    bus.in_rd         = rd;
    bus.in_imm        = imm;
  endtask

  // reference decoder: only the imm_enable output is needed here
  function automatic logic dec_imm_enable(input logic [5:0] op);
    return op == 6'b001101;
  endfunction

  logic exp_err;

  initial begin
    n_total = 0;
    n_bad   = 0;
`ifdef ENC_ILLEGAL_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    rst_n = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
    idle_req();

    // reset state
    @(negedge clk);
    chk("rst_we",    32'(imem_we), 32'h0);
    chk("rst_addr",  32'(imem_addr), 32'h0);
    chk("rst_wdata", imem_wdata, 32'h0);
    chk("rst_op",    32'(op_out), 32'h0);
    chk("rst_func",  32'(func_out), 32'h0);
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_full",  32'(full), 32'h0);
    chk("rst_err",   32'(err), 32'h0);
    chk("rst_ready", 32'(bus.in_ready), 32'h0);

    rst_n = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    // R-type add rs=1 rt=2 rd=3
    drive(1'b0, 1'b0, 1'b0, 1'b0, ALU_ADD, 5'd1, 5'd2, 5'd3, 26'd0);
    #1 chk("ready_load", 32'(bus.in_ready), 32'h1);

    @(negedge clk);
    chk("add_we",    32'(imem_we), 32'h1);
    chk("add_addr",  32'(imem_addr), 32'h0);
    chk("add_wdata", imem_wdata, 32'h00221800);
    chk("add_op",    32'(op_out), 32'h0);
    chk("add_count", 32'(count), 32'h1);
    // lw rs=5 rt=4 imm=0x10
    drive(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 5'd5, 5'd4, 5'd0, 26'h10);

    @(negedge clk);
    chk("lw_we",    32'(imem_we), 32'h1);
    chk("lw_addr",  32'(imem_addr), 32'h1);
    chk("lw_wdata", imem_wdata, 32'h8CA40010);
    // sw rs=3 rt=2 imm=4
    drive(1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 5'd3, 5'd2, 5'd0, 26'h4);

    @(negedge clk);
    chk("sw_we",    32'(imem_we), 32'h1);
    chk("sw_addr",  32'(imem_addr), 32'h2);
    chk("sw_wdata", imem_wdata, 32'hAC620004);
    chk("sw_op",    32'(op_out), 32'h2B);
    // jump with ram_load also set: jump wins
    drive(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 26'h40);

    @(negedge clk);
    chk("j_we",    32'(imem_we), 32'h1);
    chk("j_addr",  32'(imem_addr), 32'h3);
    chk("j_wdata", imem_wdata, 32'h08000040);
    chk("j_op",    32'(op_out), 32'h02);
    chk("j_func",  32'(func_out), 32'h0);
    chk("j_err",   32'(err), 32'(exp_err));
    chk("j_count", 32'(count), 32'h4);
    chk("j_full",  32'(full), 32'h1);
    // fifth request must be refused
    drive(1'b0, 1'b0, 1'b0, 1'b0, ALU_ADD, 5'd6, 5'd6, 5'd6, 26'd0);
    #1 chk("full_ready", 32'(bus.in_ready), 32'h0);

    @(negedge clk);
    chk("full_no_we", 32'(imem_we), 32'h0);
    chk("full_count", 32'(count), 32'h4);
    chk("full_ready2", 32'(bus.in_ready), 32'h0);
    idle_req();
    start = 1'b1;

    @(negedge clk);
    start = 1'b0;
    chk("restart_count", 32'(count), 32'h0);
    chk("restart_full",  32'(full), 32'h0);
    chk("restart_err",   32'(err), 32'h0);
    chk("restart_addr",  32'(imem_addr), 32'h0);
    // ori rt=1 rs=0 imm=0xFF
    drive(1'b0, 1'b0, 1'b0, 1'b1, ALU_OR, 5'd0, 5'd1, 5'd0, 26'hFF);
    #1 chk("restart_ready", 32'(bus.in_ready), 32'h1);

    @(negedge clk);
    chk("ori_we",    32'(imem_we), 32'h1);
    chk("ori_addr",  32'(imem_addr), 32'h0);
    chk("ori_wdata", imem_wdata, 32'h340100FF);
    chk("ori_func",  32'(func_out), 32'h0);
    chk("ori_dec",   32'(dec_imm_enable(op_out)), 32'h1);
    chk("ori_err",   32'(err), 32'h0);
    // R-type rs=7 rt=8 rd=9 func=010, then reset while its write is out
    drive(1'b0, 1'b0, 1'b0, 1'b0, 3'b010, 5'd7, 5'd8, 5'd9, 26'd0);

    @(posedge clk);
    #1;
    idle_req();
    chk("r2_we",    32'(imem_we), 32'h1);
    chk("r2_wdata", imem_wdata, 32'h00E84802);
    chk("r2_addr",  32'(imem_addr), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("arst_we",    32'(imem_we), 32'h0);
    chk("arst_wdata", imem_wdata, 32'h0);
    chk("arst_count", 32'(count), 32'h0);
    chk("arst_addr",  32'(imem_addr), 32'h0);

    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    // start together with valid: not accepted
    start = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, ALU_ADD, 5'd1, 5'd1, 5'd1, 26'd0);
    #1 chk("start_valid_ready", 32'(bus.in_ready), 32'h0);
    @(negedge clk);
    start = 1'b0;
    chk("start_valid_we",    32'(imem_we), 32'h0);
    chk("start_valid_count", 32'(count), 32'h0);
    // stop together with valid: not accepted, then IDLE
    stop = 1'b1;
    #1 chk("stop_valid_ready", 32'(bus.in_ready), 32'h0);
    @(negedge clk);
    stop = 1'b0;
    chk("stop_no_we", 32'(imem_we), 32'h0);
    #1 chk("idle_ready", 32'(bus.in_ready), 32'h0);
    idle_req();
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
